// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART transceiver with TX FIFO and valid/ready host ports; parity optional via UART_PARITY_EN
// Ports: clk, rst (async, active-high); tx_data/tx_valid/tx_ready push words into the TX FIFO,
//  tx_level FIFO occupancy, tx_busy FIFO or line active, uart_txd serial out (idle high);
//  uart_rxd serial in, rx_data/rx_valid/rx_ready received words, rx_parity_err travels with rx_data,
//  rx_frame_err and rx_overrun are one-cycle pulses.
module uart_fifo_core #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD = 115_200,
  parameter int DATA_W = 8,
  parameter int STOP_BITS = 1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int TXF_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [$clog2(TXF_DEPTH):0] tx_level,
  output logic tx_busy,
  output logic uart_txd,
  input  logic uart_rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic rx_valid,
  input  logic rx_ready,
  output logic rx_parity_err,
  output logic rx_frame_err,
  output logic rx_overrun
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW = $clog2(TXF_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CPB + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [3:0] LAST = 4'(DATA_W - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_PARITY_EN
    PAR,
`endif
    STOP
  } st_t;
`ifdef UART_PARITY_EN
  localparam st_t DATA_NX = PAR;
`else
  localparam st_t DATA_NX = STOP;
`endif
  logic [DATA_W-1:0] mem [TXF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign tx_ready = tx_level != (AW+1)'(TXF_DEPTH);
  assign push = tx_valid & tx_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      tx_level <= tx_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;
  st_t tx_st, tx_nx;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic tx_act, tx_end;
  always_comb begin
    tx_nx = tx_st;
    tx_end = tx_cnt == (tx_st == STOP ? STOP_END : BIT_END);
    case (tx_st)
      IDLE: tx_nx = |tx_level ? START : IDLE;
      START: tx_nx = tx_end ? DATA : START;
      DATA: tx_nx = tx_end && tx_bit == LAST ? DATA_NX : DATA;
`ifdef UART_PARITY_EN
      PAR: tx_nx = tx_end ? STOP : PAR;
`endif
      STOP: tx_nx = !tx_end ? STOP : |tx_level ? START : IDLE;
      default: tx_nx = IDLE;
    endcase
  end
  // a word leaves the FIFO on every entry into START, including back-to-back from STOP
  assign pop = tx_nx == START && tx_st != START;
  // tx_act covers the last stop-bit cycle still on the line after the FSM is back in IDLE
  assign tx_busy = |tx_level || tx_st != IDLE || tx_act;
`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk or posedge rst)
    if (rst) tx_par <= 1'b0;
    else tx_par <= pop ? ^mem[rd_ptr] ^ PARITY_ODD : tx_par;
`endif
  // uart_txd is registered from the state, so the line lags the FSM by one cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_act <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      tx_st <= tx_nx;
      tx_cnt <= tx_end || tx_st == IDLE ? '0 : tx_cnt + 1'b1;
      tx_bit <= pop ? '0 : tx_st == DATA && tx_end ? tx_bit + 1'b1 : tx_bit;
      tx_sh <= pop ? mem[rd_ptr] : tx_st == DATA && tx_end ? tx_sh >> 1 : tx_sh;
      tx_act <= tx_st != IDLE;
`ifdef UART_PARITY_EN
      uart_txd <= tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PAR ? tx_par : 1'b1;
`else
      uart_txd <= tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
`endif
    end
  logic s1, s2, s3;
  st_t rx_st, rx_nx;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic rx_end, stop_ok, load;
  always_comb begin
    rx_nx = rx_st;
    rx_end = rx_cnt == (rx_st == START ? HALF_END : BIT_END);
    case (rx_st)
      IDLE: rx_nx = s3 && !s2 ? START : IDLE;
      START: rx_nx = !rx_end ? START : s2 ? IDLE : DATA;
      DATA: rx_nx = rx_end && rx_bit == LAST ? DATA_NX : DATA;
`ifdef UART_PARITY_EN
      PAR: rx_nx = rx_end ? STOP : PAR;
`endif
      STOP: rx_nx = rx_end ? IDLE : STOP;
      default: rx_nx = IDLE;
    endcase
  end
  assign stop_ok = rx_st == STOP && rx_end && s2;
  assign load = stop_ok && (!rx_valid || rx_ready);
`ifdef UART_PARITY_EN
  logic rx_pb;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_pb <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_pb <= rx_st == PAR && rx_end ? s2 : rx_pb;
      rx_parity_err <= load ? ^{rx_sh, rx_pb} ^ PARITY_ODD : rx_parity_err;
    end
`else
  assign rx_parity_err = 1'b0;
`endif
  // s1/s2 synchronise uart_rxd; s3 is the previous s2 for start-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      s1 <= uart_rxd;
      s2 <= s1;
      s3 <= s2;
      rx_st <= rx_nx;
      rx_cnt <= rx_end || rx_st == IDLE ? '0 : rx_cnt + 1'b1;
      rx_bit <= rx_st == START ? '0 : rx_st == DATA && rx_end ? rx_bit + 1'b1 : rx_bit;
      rx_sh <= rx_st == DATA && rx_end ? {s2, rx_sh[DATA_W-1:1]} : rx_sh;
      rx_valid <= load || (rx_valid && !rx_ready);
      rx_data <= load ? rx_sh : rx_data;
      rx_frame_err <= rx_st == STOP && rx_end && !s2;
      rx_overrun <= stop_ok && rx_valid && !rx_ready;
    end
endmodule
